instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the immediate decode path: takes decoded RV32I instruction fields plus a 32-bit immediate and packs them into a 32-bit instruction word.
- Streams encoded words into instruction memory through a write port with a sequential address counter.
- Used by the boot/test-program loader and by verification to build instruction images without an external assembler.
- One registered encode stage; valid/ready on both sides.

Parameters:
- IMEM_DEPTH, 1024, instruction memory depth in 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000, byte address loaded on start; word aligned.
- ADDR_W, 32, width of mem_addr.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse: reload address counter to BASE_ADDR, clear word_count
- in_valid  input  1  field bundle valid
- in_ready  output  1  field bundle accepted when in_valid && in_ready
- in_fmt  input  3  format code: R=0, I=1, ISH=2, S=3, B=4, U=5, J=6; 7 reserved
- in_opcode  input  7  opcode[6:0]
- in_rd  input  5  rd
- in_rs1  input  5  rs1
- in_rs2  input  5  rs2
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7; used by R and ISH only
- in_imm  input  32  immediate in architectural (decoded) form
- mem_we  output  1  write valid toward instruction memory
- mem_ready  input  1  memory accepts the write when mem_we && mem_ready
- mem_addr  output  ADDR_W  byte address of the write
- mem_wdata  output  32  encoded instruction
- word_count  output  16  words written since reset/start; saturates at 16'hFFFF
- err  output  1  sticky immediate range error

Behaviour:
- Reset (synchronous, active-high): mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0, err=0. in_ready is combinational.
- in_ready = !mem_we || mem_ready. Full throughput of 1 word/cycle when mem_ready is held high.
- Latency: a bundle accepted at edge N appears on mem_we/mem_wdata after edge N; mem_addr holds the address for that word.
- mem_we, mem_addr and mem_wdata hold stable while mem_we && !mem_ready.
- On a mem handshake:
  - The address advances by 4.
  - It wraps to BASE_ADDR after IMEM_DEPTH words, i.e. offset modulo IMEM_DEPTH*4.
  - word_count increments.
- Encoding, bit ranges inclusive:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - ISH: {funct7, imm[4:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - Reserved fmt=7: word 32'h0000_0013 (NOP) and err is set.
- Unused rd/rs/funct fields for a format are ignored; immediate bits outside the field are truncated.
- start while mem_we is pending:
  - The pending word completes at its held address.
  - The reload takes effect for the next word.
  - Simultaneous start and mem handshake: the reload wins and word_count becomes 1.
- Mid-operation reset drops any pending word without writing it.
- err is cleared only by reset or start.

Optional Feature:
- Macro IMM_RANGE_CHECK_EN.
- Defined: the immediate is range-checked at acceptance; a failure sets err on the same edge the word is registered. The word is still written, truncated.
  - I, S: signed 12-bit.
  - ISH: 0..31.
  - B: signed 13-bit and imm[0]=0.
  - J: signed 21-bit and imm[0]=0.
  - U: imm[11:0]=0.
- Undefined: no checks; err is set only by reserved fmt.

Decomposition:
- Shared package instr_enc_pkg: fmt_e enum, opcode constants (OP_IMM 7'b0010011, LOAD 7'b0000011, STORE 7'b0100011, BRANCH 7'b1100011, LUI 7'b0110111, JAL 7'b1101111), NOP word.
- One combinational sub-module instr_pack: fields -> word and range_err. The top holds the handshake register, address counter and status.

Test Plan:
- I: addi x1,x0,-1 (rd=1, imm=32'hFFFF_FFFF, f3=0) -> mem_wdata 32'hFFF0_0093 at mem_addr 0; err=0.
- B: beq x1,x2,+8 -> 32'h0020_8463. With IMM_RANGE_CHECK_EN, imm=+7 -> err=1, word still written.
- J: jal x1,+2048 -> 32'h0010_00EF. U: lui x5,32'h12345000 -> 32'h1234_52B7.
- Backpressure: hold mem_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and mem_* stable; after release, 2 words land at addresses 0 and 4.
- Wrap: IMEM_DEPTH=4, stream 5 words -> 5th write at BASE_ADDR; word_count=5.
- start during a stalled write -> stalled word lands at its old address, next word lands at BASE_ADDR. reset mid-stall -> mem_we=0 next cycle and word_count=0.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// RV32I format codes, opcode constants and the NOP word shared by the encoder/loader and its users.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_ISH  = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6,
    FMT_RSVD = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: decoded fields + architectural immediate -> instruction word.
// range_err_o flags reserved formats, and out-of-range immediates when IMM_RANGE_CHECK_EN is defined.
module instr_pack
  import instr_enc_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        range_err_o
);

  fmt_e fmt;
  logic imm_bad;

  assign fmt = fmt_e'(fmt_i);

  always_comb begin
    word_o = NOP_WORD;
    case (fmt)
      FMT_R:   word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I:   word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_ISH: word_o = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S:   word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B:   word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                         imm_i[4:1], imm_i[11], opcode_i};
      FMT_U:   word_o = {imm_i[31:12], rd_i, opcode_i};
      FMT_J:   word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default: word_o = NOP_WORD;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Each check asks whether truncation to the field would lose information.
  always_comb begin
    imm_bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: imm_bad = imm_i[31:11] != {21{imm_i[11]}};
      FMT_ISH:      imm_bad = |imm_i[31:5];
      FMT_B:        imm_bad = (imm_i[31:12] != {20{imm_i[12]}}) || imm_i[0];
      FMT_J:        imm_bad = (imm_i[31:20] != {12{imm_i[20]}}) || imm_i[0];
      FMT_U:        imm_bad = |imm_i[11:0];
      default:      imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

  assign range_err_o = imm_bad || (fmt == FMT_RSVD);

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes RV32I field bundles into one registered stage and streams them to IMEM at a wrapping address.
// in_ready = !mem_we || mem_ready; optional immediate range checking under IMM_RANGE_CHECK_EN.
module instr_encoder_loader
  import instr_enc_pkg::*;
#(
  parameter int          IMEM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [15:0]       word_count,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] WRAP_MASK = ADDR_W'(IMEM_DEPTH * 4 - 1);

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              reload_q, reload_d;

  logic [31:0]       pack_word;
  logic              pack_err;
  logic              accept, mem_hs;
  logic [ADDR_W-1:0] next_addr;

  instr_pack u_pack (
    .fmt_i       (in_fmt),
    .opcode_i    (in_opcode),
    .rd_i        (in_rd),
    .rs1_i       (in_rs1),
    .rs2_i       (in_rs2),
    .funct3_i    (in_funct3),
    .funct7_i    (in_funct7),
    .imm_i       (in_imm),
    .word_o      (pack_word),
    .range_err_o (pack_err)
  );

  assign in_ready  = !we_q || mem_ready;
  assign accept    = in_valid && in_ready;
  assign mem_hs    = we_q && mem_ready;
  assign next_addr = BASE + ((addr_q - BASE + ADDR_W'(4)) & WRAP_MASK);

  always_comb begin
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;

    if (accept) begin
      we_d    = 1'b1;
      wdata_d = pack_word;
    end else if (mem_hs) begin
      we_d = 1'b0;
    end

    // A start against a stalled word is parked in reload_q so the held address stays put.
    if (mem_hs) begin
      addr_d = (reload_q || start) ? BASE : next_addr;
    end else if (start && !we_q) begin
      addr_d = BASE;
    end

    if (start) begin
      reload_d = we_q && !mem_ready;
    end else if (mem_hs) begin
      reload_d = 1'b0;
    end

    if (start) begin
      cnt_d = mem_hs ? 16'd1 : 16'd0;
    end else if (mem_hs && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end

    err_d = (err_q && !start) || (accept && pack_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q     <= 1'b0;
      addr_q   <= BASE;
      wdata_q  <= 32'h0;
      cnt_q    <= 16'h0;
      err_q    <= 1'b0;
      reload_q <= 1'b0;
    end else begin
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      reload_q <= reload_d;
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: encoding vector table, then stall/wrap/start/reset sequences against a write log.
module tb_instr_encoder_loader;
  import instr_enc_pkg::*;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Small non-zero base so wrap arithmetic is exercised relative to BASE, not zero.
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready, mem_we, mem_ready, err;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, mem_addr, mem_wdata;
  logic [15:0] word_count;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] log_a[$];
  logic [31:0] log_d[$];

  typedef struct {
    string       name;
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] word;
    bit          rbad;
  } vec_t;

  vec_t vecs[$];

  instr_encoder_loader #(
    .IMEM_DEPTH (4),
    .BASE_ADDR  (BASE),
    .ADDR_W     (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .word_count (word_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Inputs only change 1 time unit after posedge, so the negedge sees exactly what the next edge will commit.
  always @(negedge clk) begin
    if (!reset && mem_we && mem_ready) begin
      log_a.push_back(mem_addr);
      log_d.push_back(mem_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic add_vec(input string nm, input logic [2:0] fmt, input logic [6:0] op,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                         input logic [31:0] word, input bit rbad);
    vec_t v;
    v.name = nm; v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.word = word; v.rbad = rbad;
    vecs.push_back(v);
  endtask

  // addi x<rd>, x0, 0 with distinct rd values gives easily told-apart words.
  task automatic drive_addi(input logic [4:0] rd);
    in_fmt = 3'd1; in_opcode = OP_IMM; in_rd = rd; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'h0;
    in_valid = 1'b1;
  endtask

  function automatic logic [31:0] addi_word(input logic [4:0] rd);
    return {20'd0, rd, 7'b0010011};
  endfunction

  task automatic check_log(input string nm, input logic [31:0] ea[$], input logic [31:0] ed[$]);
    check({nm, "_len"}, log_a.size(), ea.size());
    for (int i = 0; i < ea.size() && i < log_a.size(); i++) begin
      check($sformatf("%s_addr%0d", nm, i), log_a[i], ea[i]);
      check($sformatf("%s_data%0d", nm, i), log_d[i], ed[i]);
    end
  endtask

  initial begin
    // Unused fields carry junk (31 / 7 / 7F / DEADBEEF) to show they are ignored.
    add_vec("addi_m1",  3'd1, OP_IMM, 5'd1,  5'd0, 5'd31, 3'd0, 7'h7F, 32'hFFFF_FFFF, 32'hFFF0_0093, 0);
    add_vec("add",      3'd0, 7'h33,  5'd3,  5'd1, 5'd2,  3'd0, 7'h00, 32'hDEAD_BEEF, 32'h0020_81B3, 0);
    add_vec("sub",      3'd0, 7'h33,  5'd3,  5'd1, 5'd2,  3'd0, 7'h20, 32'h0000_0000, 32'h4020_81B3, 0);
    add_vec("lw_m4",    3'd1, LOAD,   5'd2,  5'd3, 5'd31, 3'd2, 7'h7F, 32'hFFFF_FFFC, 32'hFFC1_A103, 0);
    add_vec("addi_ovf", 3'd1, OP_IMM, 5'd1,  5'd0, 5'd0,  3'd0, 7'h00, 32'h0000_0800, 32'h8000_0093, 1);
    add_vec("sw",       3'd3, STORE,  5'd31, 5'd1, 5'd2,  3'd2, 7'h7F, 32'h0000_0004, 32'h0020_A223, 0);
    add_vec("beq_p8",   3'd4, BRANCH, 5'd31, 5'd1, 5'd2,  3'd0, 7'h7F, 32'h0000_0008, 32'h0020_8463, 0);
    add_vec("beq_p7",   3'd4, BRANCH, 5'd31, 5'd1, 5'd2,  3'd0, 7'h7F, 32'h0000_0007, 32'h0020_8363, 1);
    add_vec("jal_2048", 3'd6, JAL,    5'd1,  5'd31, 5'd31, 3'd7, 7'h7F, 32'h0000_0800, 32'h0010_00EF, 0);
    add_vec("jal_m4",   3'd6, JAL,    5'd0,  5'd31, 5'd31, 3'd7, 7'h7F, 32'hFFFF_FFFC, 32'hFFDF_F06F, 0);
    add_vec("lui",      3'd5, LUI,    5'd5,  5'd31, 5'd31, 3'd7, 7'h7F, 32'h1234_5000, 32'h1234_52B7, 0);
    add_vec("lui_low",  3'd5, LUI,    5'd5,  5'd31, 5'd31, 3'd7, 7'h7F, 32'h1234_5001, 32'h1234_52B7, 1);
    add_vec("srai",     3'd2, OP_IMM, 5'd5,  5'd6, 5'd31, 3'd5, 7'h20, 32'h0000_0003, 32'h4033_5293, 0);
    add_vec("slli_32",  3'd2, OP_IMM, 5'd1,  5'd1, 5'd31, 3'd1, 7'h00, 32'h0000_0020, 32'h0000_9093, 1);
    add_vec("rsvd",     3'd7, 7'h33,  5'd3,  5'd1, 5'd2,  3'd0, 7'h00, 32'h0000_0000, 32'h0000_0013, 0);

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    in_fmt = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'h0;
    repeat (2) tick();
    check("rst_we",    mem_we,     0);
    check("rst_addr",  mem_addr,   BASE);
    check("rst_wdata", mem_wdata,  0);
    check("rst_count", word_count, 0);
    check("rst_err",   err,        0);
    check("rst_ready", in_ready,   1);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      vec_t v;
      logic exp_err;
      v = vecs[i];
      exp_err = (v.fmt == 3'd7) || (CHK && v.rbad);
      pulse_start();
      in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
      in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({v.name, "_we"},    mem_we,    1);
      check({v.name, "_word"},  mem_wdata, v.word);
      check({v.name, "_addr"},  mem_addr,  BASE);
      check({v.name, "_err"},   err,       exp_err);
      tick();
      check({v.name, "_count"}, word_count, 1);
      check({v.name, "_idle"},  mem_we,     0);
    end

    // err is sticky across later good words and cleared by start.
    pulse_start();
    in_fmt = 3'd7; in_valid = 1'b1;
    tick();
    drive_addi(5'd1);
    tick();
    in_valid = 1'b0;
    tick();
    check("sticky_err", err, 1);
    pulse_start();
    check("start_clr_err", err, 0);

    // Backpressure: three stalled cycles, then both words drain to BASE and BASE+4.
    log_a.delete(); log_d.delete();
    mem_ready = 1'b0;
    drive_addi(5'd1);
    tick();
    drive_addi(5'd2);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_ready%0d", k), in_ready,  0);
      check($sformatf("bp_we%0d", k),    mem_we,    1);
      check($sformatf("bp_data%0d", k),  mem_wdata, addi_word(5'd1));
      check($sformatf("bp_addr%0d", k),  mem_addr,  BASE);
      tick();
    end
    mem_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check_log("bp", '{BASE, BASE + 32'd4}, '{addi_word(5'd1), addi_word(5'd2)});
    check("bp_count", word_count, 2);

    // Wrap: depth 4, five back-to-back words; fifth returns to BASE.
    pulse_start();
    log_a.delete(); log_d.delete();
    for (int k = 0; k < 5; k++) begin
      drive_addi(5'(k + 1));
      tick();
    end
    in_valid = 1'b0;
    tick();
    check_log("wrap", '{BASE, BASE + 32'd4, BASE + 32'd8, BASE + 32'd12, BASE},
              '{addi_word(5'd1), addi_word(5'd2), addi_word(5'd3), addi_word(5'd4), addi_word(5'd5)});
    check("wrap_count", word_count, 5);
    check("wrap_addr_after", mem_addr, BASE + 32'd4);

    // start during a stall: stalled word keeps BASE+4, following word goes to BASE.
    log_a.delete(); log_d.delete();
    mem_ready = 1'b0;
    drive_addi(5'd6);
    tick();
    in_valid = 1'b0;
    pulse_start();
    check("sst_hold_addr", mem_addr,   BASE + 32'd4);
    check("sst_hold_we",   mem_we,     1);
    check("sst_count",     word_count, 0);
    mem_ready = 1'b1;
    drive_addi(5'd7);
    tick();
    in_valid = 1'b0;
    tick();
    check_log("sst", '{BASE + 32'd4, BASE}, '{addi_word(5'd6), addi_word(5'd7)});
    check("sst_count_end", word_count, 2);

    // start coinciding with the handshake: reload wins, count restarts at 1.
    log_a.delete(); log_d.delete();
    mem_ready = 1'b0;
    drive_addi(5'd8);
    tick();
    in_valid = 1'b0;
    tick();
    start = 1'b1; mem_ready = 1'b1;
    tick();
    start = 1'b0;
    check("sim_count", word_count, 1);
    check("sim_addr",  mem_addr,   BASE);
    check("sim_we",    mem_we,     0);
    drive_addi(5'd9);
    tick();
    in_valid = 1'b0;
    tick();
    check_log("sim", '{BASE + 32'd4, BASE}, '{addi_word(5'd8), addi_word(5'd9)});

    // Reset while stalled: pending word is dropped, never written.
    log_a.delete(); log_d.delete();
    mem_ready = 1'b0;
    drive_addi(5'd10);
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("mrst_we",    mem_we,     0);
    check("mrst_count", word_count, 0);
    check("mrst_addr",  mem_addr,   BASE);
    check("mrst_wdata", mem_wdata,  0);
    reset = 1'b0; mem_ready = 1'b1;
    repeat (2) tick();
    check("mrst_nowrite", log_a.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
